// File: rtl/spi_cfg_pkg.sv
// Shared definitions for the SPI configuration master: frame layout, FSM
// state encoding and the peripheral register map.
package spi_cfg_pkg;

   localparam int FRAME_W     = 16;
   localparam int WR_FLAG_POS = FRAME_W - 1;
   localparam int ADDR_W      = 7;
   localparam int DATA_W      = 8;
   localparam int NUM_REQ     = 2;

   // State encoding kept as plain constants; the enum mirrors it for debug visibility.
   typedef logic [2:0] spi_state_t;
   localparam spi_state_t ST_IDLE  = 3'd0;
   localparam spi_state_t ST_SETUP = 3'd1;
   localparam spi_state_t ST_SHIFT = 3'd2;
   localparam spi_state_t ST_HOLD  = 3'd3;
   localparam spi_state_t ST_GAP   = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE  = ST_IDLE,
      S_SETUP = ST_SETUP,
      S_SHIFT = ST_SHIFT,
      S_HOLD  = ST_HOLD,
      S_GAP   = ST_GAP
   } spi_state_e;

   localparam logic [ADDR_W-1:0] EN_OUT_LO = 7'h00;
   localparam logic [ADDR_W-1:0] EN_OUT_HI = 7'h01;
   localparam logic [ADDR_W-1:0] EN_PWM_LO = 7'h02;
   localparam logic [ADDR_W-1:0] EN_PWM_HI = 7'h03;
   localparam logic [ADDR_W-1:0] PWM_DUTY  = 7'h04;

   function automatic logic [FRAME_W-1:0] build_frame(input logic [ADDR_W-1:0] addr,
                                                      input logic [DATA_W-1:0] data);
      return {1'b1, addr, data};
   endfunction

endpackage

// File: rtl/spi_cfg_master_tick.sv
// Half-period tick generator: one-cycle tick every CLK_DIV enabled cycles,
// counter held at zero while disabled.
module spi_tick_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   logic [7:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || !en) begin
         cnt <= 8'd0;
      end else if (cnt == DIV_LAST) begin
         cnt <= 8'd0;
      end else begin
         cnt <= cnt + 8'd1;
      end
   end

   assign tick = en && (cnt == DIV_LAST);

endmodule

// File: rtl/spi_cfg_master.sv
// Two-requester SPI mode-0 write master: round-robin arbitration in IDLE,
// then one 16-bit {write flag, addr, data} frame shifted out MSB first.
module spi_cfg_master
   import spi_cfg_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int CS_GAP  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  req_valid,
   input  logic [13:0] req_addr,
   input  logic [15:0] req_data,
   output logic [1:0]  req_ready,
   output logic        ncs,
   output logic        sclk,
   output logic        copi,
   output logic        busy,
   output logic        done,
   output logic        done_id,
   output spi_state_e  state_dbg
);

   localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

   spi_state_t         state;
   logic               rr_ptr;
   logic               cur_id;
   logic               phase;
   logic [3:0]         bit_cnt;
   logic [3:0]         next_bit;
   logic [7:0]         gap_cnt;
   logic [FRAME_W-1:0] frame;
   logic [FRAME_W-1:0] new_frame;
   logic [1:0]         grant;
   logic               grant_id;
   logic               accept;
   logic               tick;
   logic               tick_en;
   logic [6:0]         sel_addr;
   logic [7:0]         sel_data;

   // Handshake: requester i is accepted on a cycle where req_valid[i] and
   // req_ready[i] are both high; ready is only offered in IDLE, to the single
   // round-robin winner, so a valid dropped before ready is simply never granted.
   always_comb begin
      grant_id = rr_ptr;
      if (!req_valid[rr_ptr] && req_valid[~rr_ptr]) begin
         grant_id = ~rr_ptr;
      end
      grant     = req_valid & (2'b01 << grant_id);
      req_ready = ((state == ST_IDLE) && !rst) ? grant : 2'b00;
      accept    = |req_ready;
      sel_addr  = grant_id ? req_addr[13:7] : req_addr[6:0];
      sel_data  = grant_id ? req_data[15:8] : req_data[7:0];
      new_frame = build_frame(sel_addr, sel_data);
      next_bit  = bit_cnt - 4'd1;
      tick_en   = (state == ST_SETUP) || (state == ST_SHIFT) || (state == ST_HOLD);
      busy      = (state != ST_IDLE) && !rst;
      state_dbg = spi_state_e'(state);
   end

   spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .en   (tick_en),
      .tick (tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         rr_ptr  <= 1'b0;
         cur_id  <= 1'b0;
         phase   <= 1'b0;
         bit_cnt <= 4'd0;
         gap_cnt <= 8'd0;
         frame   <= '0;
         ncs     <= 1'b1;
         sclk    <= 1'b0;
         copi    <= 1'b0;
         done    <= 1'b0;
         done_id <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  frame   <= new_frame;
                  cur_id  <= grant_id;
                  rr_ptr  <= ~grant_id;
                  bit_cnt <= 4'd15;
                  phase   <= 1'b0;
                  ncs     <= 1'b0;
                  sclk    <= 1'b0;
                  copi    <= new_frame[WR_FLAG_POS];
                  state   <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (tick) begin
                  state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               // phase 0 = sclk low half, phase 1 = sclk high half of bit_cnt
               if (tick) begin
                  if (!phase) begin
                     sclk  <= 1'b1;
                     phase <= 1'b1;
                  end else begin
                     sclk  <= 1'b0;
                     phase <= 1'b0;
                     if (bit_cnt == 4'd0) begin
                        copi  <= 1'b0;
                        state <= ST_HOLD;
                     end else begin
                        bit_cnt <= next_bit;
                        copi    <= frame[next_bit];
                     end
                  end
               end
            end
            ST_HOLD: begin
               if (tick) begin
                  ncs     <= 1'b1;
                  done    <= 1'b1;
                  done_id <= cur_id;
                  gap_cnt <= 8'd0;
                  state   <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  state <= ST_IDLE;
               end else begin
                  gap_cnt <= gap_cnt + 8'd1;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_cfg_master.sv
// Directed bench for spi_cfg_master: a fast instance (CLK_DIV=2) for function,
// arbitration and abort, and a slow instance (CLK_DIV=255) for divider range.
`timescale 1ns/1ps
module tb_spi_cfg_master;
   import spi_cfg_pkg::*;

   localparam int A_DIV = 2;
   localparam int A_GAP = 4;
   localparam int B_DIV = 255;
   localparam int B_GAP = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [1:0]  a_valid, b_valid;
   logic [13:0] a_addr, b_addr;
   logic [15:0] a_data, b_data;
   logic [1:0]  a_ready, b_ready;
   logic        a_ncs, a_sclk, a_copi, a_busy, a_done, a_done_id;
   logic        b_ncs, b_sclk, b_copi, b_busy, b_done, b_done_id;
   spi_state_e  a_state, b_state;

   spi_cfg_master #(.CLK_DIV(A_DIV), .CS_GAP(A_GAP)) dut_a (
      .clk(clk), .rst(rst), .req_valid(a_valid), .req_addr(a_addr), .req_data(a_data),
      .req_ready(a_ready), .ncs(a_ncs), .sclk(a_sclk), .copi(a_copi), .busy(a_busy),
      .done(a_done), .done_id(a_done_id), .state_dbg(a_state)
   );

   spi_cfg_master #(.CLK_DIV(B_DIV), .CS_GAP(B_GAP)) dut_b (
      .clk(clk), .rst(rst), .req_valid(b_valid), .req_addr(b_addr), .req_data(b_data),
      .req_ready(b_ready), .ncs(b_ncs), .sclk(b_sclk), .copi(b_copi), .busy(b_busy),
      .done(b_done), .done_id(b_done_id), .state_dbg(b_state)
   );

   int checks = 0;
   int errors = 0;
   logic [16:0] exp_q[$];   // {requester id, frame}
   int gap_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Frame monitor for the fast instance
   logic        a_pn = 1'b1, a_ps = 1'b0, a_pc = 1'b0;
   int          a_rises = 0, a_low = 0, a_high = 0, a_dones = 0;
   logic [15:0] a_shreg = '0;
   logic [16:0] a_e;

   always @(negedge clk) begin
      if (a_pn && !a_ncs) begin
         gap_q.push_back(a_high);
         a_high = 0; a_rises = 0; a_low = 0; a_shreg = '0;
      end
      if (a_ncs) a_high++; else a_low++;
      if (!a_ncs && !a_ps && a_sclk) begin
         a_shreg = {a_shreg[14:0], a_copi};
         a_rises++;
         check("a_ready_in_frame", a_ready, 2'b00);
      end
      if (!a_ncs && !a_pn && a_copi !== a_pc) check("a_copi_on_fall", {a_ps, a_sclk}, 2'b10);
      if (a_done) begin
         a_dones++;
         check("a_done_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            a_e = exp_q.pop_front();
            check("a_frame", a_shreg, a_e[15:0]);
            check("a_done_id", a_done_id, a_e[16]);
            check("a_bits", a_rises, 16);
            check("a_ncs_low", a_low, 34 * A_DIV);
         end
      end
      a_pn = a_ncs; a_ps = a_sclk; a_pc = a_copi;
   end

   // Half-period and frame monitor for the slow instance
   logic        b_pn = 1'b1, b_ps = 1'b0, b_pc = 1'b0;
   int          b_rises = 0, b_run = 0, b_dones = 0;
   logic [15:0] b_shreg = '0;
   logic [16:0] b_e;

   always @(negedge clk) begin
      if (b_pn && !b_ncs) begin
         b_run = 0; b_rises = 0; b_shreg = '0;
      end
      if (!b_ncs) begin
         if (!b_pn && b_sclk !== b_ps) begin
            if (b_sclk) begin
               if (b_rises == 0) check("b_first_low", b_run, 2 * B_DIV);
               else check("b_low_half", b_run, B_DIV);
               b_shreg = {b_shreg[14:0], b_copi};
               b_rises++;
            end else begin
               check("b_high_half", b_run, B_DIV);
            end
            b_run = 1;
         end else begin
            b_run++;
         end
         if (!b_pn && b_copi !== b_pc) check("b_copi_on_fall", {b_ps, b_sclk}, 2'b10);
      end
      if (b_done) begin
         b_dones++;
         check("b_done_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            b_e = exp_q.pop_front();
            check("b_frame", b_shreg, b_e[15:0]);
            check("b_done_id", b_done_id, b_e[16]);
            check("b_bits", b_rises, 16);
         end
      end
      b_pn = b_ncs; b_ps = b_sclk; b_pc = b_copi;
   end

   task automatic send_a(input int id, input logic [6:0] addr, input logic [7:0] data);
      int n = 0;
      @(negedge clk);
      a_addr[7*id +: 7] = addr;
      a_data[8*id +: 8] = data;
      a_valid[id] = 1'b1;
      exp_q.push_back({id[0], build_frame(addr, data)});
      #1;
      while (!a_ready[id] && n < 400) begin
         @(negedge clk); #1;
         n++;
      end
      check("a_accept_timeout", n < 400, 1);
      @(posedge clk); #1;
      a_valid[id] = 1'b0;
   endtask

   task automatic wait_a_dones(input int target, input int budget, input string tag);
      int n = 0;
      while (a_dones < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, a_dones >= target, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt, n, dones_before;
      logic [1:0]  exp_g;
      logic [16:0] dropped;

      a_valid = '0; a_addr = '0; a_data = '0;
      b_valid = '0; b_addr = '0; b_data = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);

      // Reset values with requests pending
      @(negedge clk);
      a_valid = 2'b11; b_valid = 2'b11;
      #1;
      check("rst_ready", a_ready, 2'b00);
      check("rst_ncs", a_ncs, 1'b1);
      check("rst_sclk", a_sclk, 1'b0);
      check("rst_copi", a_copi, 1'b0);
      check("rst_busy", a_busy, 1'b0);
      check("rst_done", a_done, 1'b0);
      check("rst_done_id", a_done_id, 1'b0);
      check("rst_state", a_state, S_IDLE);
      check("rst_b_ready", b_ready, 2'b00);
      check("rst_b_ncs", b_ncs, 1'b1);
      @(negedge clk);
      a_valid = '0; b_valid = '0; rst = 1'b0;

      // Single write: PWM_DUTY <= 0xA5
      send_a(0, PWM_DUTY, 8'hA5);
      void'(exp_q.pop_back());
      exp_q.push_back({1'b0, 16'h84A5});
      check("a_busy_in_frame", a_busy, 1'b1);
      wait_a_dones(1, 300, "a_done_timeout_single");

      // Simultaneous requests after reset: grants alternate 0,1,0,1
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      a_addr = {EN_OUT_HI, EN_OUT_LO};
      a_data = {8'h22, 8'h11};
      for (int i = 0; i < 4; i++) begin
         if (i % 2 == 0) exp_q.push_back({1'b0, 16'h8011});
         else exp_q.push_back({1'b1, 16'h8122});
      end
      dones_before = a_dones;
      a_valid = 2'b11;
      cnt = 0; n = 0;
      while (cnt < 4 && n < 2000) begin
         #1;
         if (a_ready != 2'b00) begin
            exp_g = (cnt % 2 == 0) ? 2'b01 : 2'b10;
            check("a_rr_order", a_ready, exp_g);
            cnt++;
            if (cnt == 4) begin
               @(posedge clk); #1;
               a_valid = 2'b00;
            end
         end
         @(negedge clk);
         n++;
      end
      check("a_rr_grants", cnt, 4);
      wait_a_dones(dones_before + 4, 600, "a_done_timeout_rr");

      // Requester 1 back-to-back: ncs high exactly CS_GAP+1 between frames
      repeat (10) @(negedge clk);
      gap_q.delete();
      dones_before = a_dones;
      a_addr[13:7] = EN_PWM_LO;
      a_data[15:8] = 8'h5A;
      for (int i = 0; i < 3; i++) exp_q.push_back({1'b1, 16'h825A});
      a_valid[1] = 1'b1;
      cnt = 0; n = 0;
      while (cnt < 3 && n < 2000) begin
         #1;
         if (a_ready[1]) begin
            cnt++;
            if (cnt == 3) begin
               @(posedge clk); #1;
               a_valid[1] = 1'b0;
            end
         end
         @(negedge clk);
         n++;
      end
      check("a_b2b_grants", cnt, 3);
      wait_a_dones(dones_before + 3, 400, "a_done_timeout_b2b");
      check("a_gap_count", gap_q.size(), 3);
      if (gap_q.size() >= 3) begin
         check("a_gap_1", gap_q[1], A_GAP + 1);
         check("a_gap_2", gap_q[2], A_GAP + 1);
      end

      // Abort during SHIFT bit 7
      repeat (10) @(negedge clk);
      send_a(0, EN_PWM_HI, 8'h3C);
      n = 0;
      while (!(a_rises == 8 && a_sclk == 1'b0 && a_ncs == 1'b0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("a_reach_bit7", n < 200, 1);
      dones_before = a_dones;
      rst = 1'b1;
      dropped = exp_q.pop_front();
      @(posedge clk); #1;
      check("abort_ncs", a_ncs, 1'b1);
      check("abort_sclk", a_sclk, 1'b0);
      check("abort_copi", a_copi, 1'b0);
      check("abort_busy", a_busy, 1'b0);
      check("abort_done", a_done, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort_state", a_state, S_IDLE);
      check("abort_busy_after", a_busy, 1'b0);
      repeat (20) @(negedge clk);
      check("abort_no_done", a_dones, dones_before);
      send_a(1, EN_OUT_LO, 8'hC3);
      wait_a_dones(dones_before + 1, 300, "a_done_timeout_after_abort");

      // Slow divider instance
      @(negedge clk);
      b_addr[6:0] = EN_OUT_HI;
      b_data[7:0] = 8'h96;
      exp_q.push_back({1'b0, 16'h8196});
      b_valid[0] = 1'b1;
      #1;
      check("b_ready_idle", b_ready, 2'b01);
      @(posedge clk); #1;
      b_valid[0] = 1'b0;
      n = 0;
      while (b_dones < 1 && n < 10000) begin
         @(negedge clk);
         n++;
      end
      check("b_done_timeout", b_dones, 1);
      repeat (B_GAP + 2) @(negedge clk);
      check("b_state_end", b_state, S_IDLE);
      check("exp_q_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_cfg_master.md
SPI_CFG_MASTER -- requirements
Module: spi_cfg_master

Interface
REQ-001 Parameter CLK_DIV, default 4, meaning clk cycles per SCLK half-period; legal range 2..255.
REQ-002 Parameter CS_GAP, default 4, meaning minimum clk cycles NCS is held high after a frame before the next frame may start; legal range 2..255.
REQ-003 clk  input  1  single block clock; all logic SHALL be clocked on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req_valid  input  2  per-requester write request; bit i belongs to requester i.
REQ-006 req_addr  input  14  packed 7-bit register addresses; requester i uses bits [7i+6:7i].
REQ-007 req_data  input  16  packed 8-bit write data; requester i uses bits [8i+7:8i].
REQ-008 req_ready  output  2  per-requester accept; a request is accepted on a cycle where req_valid[i] and req_ready[i] are both 1.
REQ-009 ncs  output  1  SPI chip select, active-low, registered.
REQ-010 sclk  output  1  SPI clock, mode 0 (idles low), registered.
REQ-011 copi  output  1  SPI serial data to the peripheral, registered.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.
REQ-013 done  output  1  one-cycle pulse on frame completion.
REQ-014 done_id  output  1  index of the requester whose frame completed; valid while done=1.

Function
REQ-015 The FSM SHALL have the states IDLE, SETUP, SHIFT, HOLD and GAP.
REQ-016 Frame format: 16 bits {1'b1 write flag, addr[6:0], data[7:0]}, shifted out MSB first.
REQ-017 Arbitration SHALL happen only in IDLE, using round-robin over the valid bits: the requester not granted last wins a tie, and the pointer favours requester 0 after reset.
REQ-018 req_ready SHALL be combinational and equal to (state==IDLE) AND the grant vector, so at most one bit is high per cycle; req_ready SHALL be 0 outside IDLE.
REQ-019 On the accept cycle N the block SHALL latch the frame and requester id, update the RR pointer, and enter SETUP at N+1.
REQ-020 SETUP: ncs=0, sclk=0, copi=frame[15], for CLK_DIV cycles; then enter SHIFT.
REQ-021 SHIFT, for bit k=15..0: sclk low for CLK_DIV cycles then high for CLK_DIV cycles, with copi=frame[k] stable across both phases.
REQ-022 copi SHALL change only at the cycle on which sclk goes low; 16 rising sclk edges per frame exactly.
REQ-023 HOLD: ncs=0, sclk=0, for CLK_DIV cycles after the last high phase; then enter GAP.
REQ-024 GAP: ncs=1, sclk=0, copi=0, for CS_GAP cycles; done=1 with done_id on the first GAP cycle; then enter IDLE.
REQ-025 NCS-low duration SHALL be exactly 34*CLK_DIV cycles per frame.
REQ-026 NCS-high time between back-to-back frames SHALL be at least CS_GAP+1 cycles (GAP plus the IDLE accept cycle).
REQ-027 Valid bits arriving while busy SHALL be held pending, with no effect until IDLE.
REQ-028 A requester deasserting valid before ready is tolerated: it receives no grant and is not transmitted.
REQ-029 The shift counter SHALL be 4 bits; the divider counter SHALL be 8 bits and wrap to 0 at CLK_DIV-1.

Reset
REQ-030 While rst=1 the outputs SHALL be: ncs=1, sclk=0, copi=0, busy=0, done=0, done_id=0, req_ready=0.
REQ-031 Reset SHALL also set state=IDLE, the RR pointer to favour requester 0, and clear all counters and the frame register.
REQ-032 rst asserted mid-frame SHALL abort the frame: ncs=1 on the next cycle, no done pulse, and the frame is not retried.

Structure
REQ-033 Shared package spi_cfg_pkg SHALL hold the FSM state enum, FRAME_W=16, the write-flag position, and the register address constants 0x00..0x04 (EN_OUT_LO, EN_OUT_HI, EN_PWM_LO, EN_PWM_HI, PWM_DUTY).
REQ-034 One sub-module, spi_tick_gen, SHALL produce a one-cycle half-period tick every CLK_DIV cycles while enabled; it SHALL clear when disabled.

Verification
REQ-035 CLK_DIV=2, CS_GAP=4; requester 0 writes addr 0x04 data 0xA5 -> copi sampled on sclk rises = 0x84A5, ncs low 68 cycles, done with done_id=0.
REQ-036 Both valid on the same cycle after reset -> requester 0 is granted first, requester 1 second; with both held valid the grants alternate 0,1,0,1.
REQ-037 Requester 1 holds valid for back-to-back frames -> ncs high exactly CS_GAP+1=5 cycles between frames, and req_ready=0 throughout each frame.
REQ-038 rst=1 during SHIFT bit 7 -> next cycle ncs=1, sclk=0, busy=0, no done; a new request afterwards completes normally.
REQ-039 CLK_DIV=255 -> every sclk half-period is 255 cycles, no counter overflow, and copi changes only on sclk falling edges.
